// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath.
// Drives datapath enables from registered state, isBne and the wait counter.
module multicycle_control #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       Beq,
    output logic       Bne,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegalOp,
    output logic [3:0] state
);

    localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_WAIT);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ILLEGAL = 4'd12
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          isbne_q, isbne_d;
    logic          last;

    assign last  = (cnt_q == LAST);
    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            isbne_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            isbne_q <= isbne_d;
        end
    end

    // Wait counter only advances in memory states; any other path clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        isbne_d = isbne_q;
        case (state_q)
            S_FETCH: begin
                if (last) begin
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                isbne_d = (opcode == OP_BNE);
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_R:           state_d = S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDIEX;
                    default:        state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (last) begin
                    state_d = S_MEMWB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEMWR: begin
                if (last) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        Beq       = 1'b0;
        Bne       = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        MemToReg  = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        PCSource  = 2'b00;
        illegalOp = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = last;
                PCWrite = last;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                Beq      = ~isbne_q;
                Bne      = isbne_q;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB:  RegWrite  = 1'b1;
            S_ILLEGAL: illegalOp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multicycle MIPS datapath. It is the sequential successor to the single-cycle opcode decoder and drives all datapath enables across the fetch, decode, execute, memory and writeback steps. It adds BNE, ADDI, illegal-opcode trapping and a parametrised memory wait-state count.

## Interface
- MEM_WAIT, 0, extra cycles held in every memory-access state (0..15); counter width max(1, clog2(MEM_WAIT+1))
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until next FETCH completes
- PCWrite  out  1  unconditional PC load
- Beq  out  1  PC load if ALU zero
- Bne  out  1  PC load if ALU not zero
- IorD  out  1  memory address select (0=PC, 1=ALUOut)
- MemRead  out  1  memory read
- MemWrite  out  1  memory write
- IRWrite  out  1  instruction register load
- MemToReg  out  1  writeback source (1=MDR)
- RegDst  out  1  destination register (1=rd, 0=rt)
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=4, 10=signext, 11=signext<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegalOp  out  1  one-cycle trap pulse
- state  out  4  current state code, for debug

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ILLEGAL=12. Codes 13–15 go to FETCH.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, j=000010, addi=001000. Anything else is illegal.
- Transitions:
  - FETCH→DECODE
  - DECODE→MEMADR (lw/sw), EXEC (R), BRANCH (beq/bne), JUMP (j), ADDIEX (addi), ILLEGAL (other)
  - MEMADR→MEMRD (lw) or MEMWR (sw)
  - MEMRD→MEMWB
  - EXEC→RWB
  - ADDIEX→ADDIWB
  - MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB, ILLEGAL→FETCH
- Wait states: FETCH, MEMRD and MEMWR each last MEM_WAIT+1 cycles, counted by an internal wait counter. The counter clears on state exit.
- In DECODE, the register isBne captures (opcode==000101). BRANCH uses the registered value, not live opcode.
- Outputs per state (unlisted outputs are 0):
  - FETCH: MemRead=1, ALUSrcB=01. IRWrite=1 and PCWrite=1 only in the last wait cycle.
  - DECODE: ALUSrcB=11
  - MEMADR: ALUSrcA=1, ALUSrcB=10
  - MEMRD: MemRead=1, IorD=1
  - MEMWB: RegWrite=1, MemToReg=1
  - MEMWR: MemWrite=1, IorD=1, held for all wait cycles
  - EXEC: ALUSrcA=1, ALUOp=10
  - RWB: RegWrite=1, RegDst=1
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, Beq=~isBne, Bne=isBne
  - JUMP: PCWrite=1, PCSource=10
  - ADDIEX: ALUSrcA=1, ALUSrcB=10
  - ADDIWB: RegWrite=1
  - ILLEGAL: illegalOp=1
- All outputs are decoded from registered state, isBne and the wait counter only. No combinational path from opcode to outputs.

## Timing
- Reset: state=FETCH, wait counter=0, isBne=0, immediately on rst_n low. Outputs take FETCH values; with MEM_WAIT=0 that means IRWrite=PCWrite=1 during reset.
- Reset mid-instruction aborts it. No write enable may be asserted after rst_n falls except FETCH values.
- Instruction latency (cycles, W=MEM_WAIT):
  - lw: 5+2W
  - sw: 4+2W
  - R and addi: 4+W
  - beq/bne and j: 3+W
  - illegal: 3+W
- Exactly one of PCWrite, Beq, Bne is asserted per cycle at most.
- RegWrite and MemWrite are never asserted together.

## Test plan
- MEM_WAIT=0, reset, opcode=000000: state sequence 0,1,6,7,0. RegWrite=1 with RegDst=1 at cycle 4 only; ALUOp=10 in EXEC.
- MEM_WAIT=0, lw (100011): sequence 0,1,2,3,4. MemToReg=RegWrite=1 in cycle 5; next instruction fetch starts at cycle 6.
- MEM_WAIT=2, sw (101011): FETCH holds 3 cycles with IRWrite only on the 3rd; MEMWR holds 3 cycles with MemWrite=1 throughout; total 8 cycles.
- beq (000100), then bne (000101): BRANCH asserts Beq=1/Bne=0, then Bne=1/Beq=0. Changing opcode during BRANCH does not change the outputs.
- opcode=111011 then 100001: DECODE→ILLEGAL, illegalOp=1 for exactly one cycle, then FETCH; no RegWrite or MemWrite at any point.
- Drop rst_n in the middle of MEMWR (MEM_WAIT=3): MemWrite falls in the same cycle, state=0 and counter=0. After release, a fresh fetch holds 4 cycles.
